// File: rtl/rf_multiport_ce.sv
// rf_multiport_ce: WIDTH x DEPTH register file, one write and two registered read ports, global clk_en.
// Read latency is one enabled edge. RF_WRITE_BYPASS_EN selects write-first on same-address collisions.
// No backpressure: one write and two reads are taken every enabled cycle; clk_en low freezes all state.
module rf_multiport_ce #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned AW      = $clog2(DEPTH),
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic             clk_n,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re_a,
  input  logic [AW-1:0]    raddr_a,
  input  logic             re_b,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             rvalid_a,
  output logic             rvalid_b
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  // Address maps to real storage: in range and not the hard-wired zero entry.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && !(ZERO_R0 && (a == '0));
  endfunction

  function automatic logic [WIDTH-1:0] rd_val(input logic [AW-1:0] a);
    logic [WIDTH-1:0] v;
    v = '0;
    if (addr_ok(a)) begin
`ifdef RF_WRITE_BYPASS_EN
      if (wr_ok && (a == waddr)) v = wdata;
      else                       v = mem[a];
`else
      v = mem[a];
`endif
    end
    return v;
  endfunction

  always_comb begin
    wr_ok = we && addr_ok(waddr);
    rd_a  = rd_val(raddr_a);
    rd_b  = rd_val(raddr_b);
  end

  always_ff @(posedge clk_n or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      rdata_a  <= '0;
      rdata_b  <= '0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
    end else if (clk_en) begin
      if (wr_ok) mem[waddr] <= wdata;
      if (re_a)  rdata_a <= rd_a;
      if (re_b)  rdata_b <= rd_b;
      rvalid_a <= re_a;
      rvalid_b <= re_b;
    end
  end

endmodule

// File: tb/tb_rf_multiport_ce.sv
// Randomised bench for rf_multiport_ce: a default instance and a DEPTH=6, ZERO_R0=1 instance share stimulus
// and are each compared against an array-based reference model of the register file.
module tb_rf_multiport_ce;
  logic        clk_n = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b0;
  logic        we = 1'b0;
  logic        re_a = 1'b0;
  logic        re_b = 1'b0;
  logic [2:0]  waddr = '0;
  logic [2:0]  raddr_a = '0;
  logic [2:0]  raddr_b = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rda [2];
  logic [15:0] rdb [2];
  logic        va [2];
  logic        vb [2];

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: entry contents and expected output registers per instance.
  logic [15:0] m   [2][8];
  logic [15:0] ea  [2];
  logic [15:0] eb  [2];
  logic        eva [2];
  logic        evb [2];
  int          dep [2] = '{8, 6};
  bit          zr  [2] = '{1'b0, 1'b1};

  rf_multiport_ce dut0 (
    .clk_n(clk_n), .rst(rst), .clk_en(clk_en), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .re_b(re_b), .raddr_b(raddr_b),
    .rdata_a(rda[0]), .rdata_b(rdb[0]), .rvalid_a(va[0]), .rvalid_b(vb[0])
  );

  rf_multiport_ce #(.WIDTH(16), .DEPTH(6), .ZERO_R0(1'b1)) dut1 (
    .clk_n(clk_n), .rst(rst), .clk_en(clk_en), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .re_b(re_b), .raddr_b(raddr_b),
    .rdata_a(rda[1]), .rdata_b(rdb[1]), .rvalid_a(va[1]), .rvalid_b(vb[1])
  );

  always #5 clk_n = ~clk_n;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_rd(input int d, input logic [2:0] a, input bit wok);
    if (int'(a) >= dep[d] || (zr[d] && a == '0)) return 16'h0000;
`ifdef RF_WRITE_BYPASS_EN
    if (wok && a == waddr) return wdata;
`endif
    return m[d][a];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) m[d][i] = 16'h0000;
      ea[d] = 16'h0000; eb[d] = 16'h0000; eva[d] = 1'b0; evb[d] = 1'b0;
    end
  endtask

  // Applies one rising edge worth of the rules to the model using the current inputs.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      bit wok;
      wok = we && (int'(waddr) < dep[d]) && !(zr[d] && waddr == '0);
      if (clk_en) begin
        if (re_a) ea[d] = model_rd(d, raddr_a, wok);
        if (re_b) eb[d] = model_rd(d, raddr_b, wok);
        eva[d] = re_a;
        evb[d] = re_b;
        if (wok) m[d][waddr] = wdata;
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("rdata_a%0d", d), rda[d], ea[d]);
      check_eq($sformatf("rdata_b%0d", d), rdb[d], eb[d]);
      check_eq($sformatf("rvalid_a%0d", d), 16'(va[d]), 16'(eva[d]));
      check_eq($sformatf("rvalid_b%0d", d), 16'(vb[d]), 16'(evb[d]));
    end
  endtask

  // Called 1 time unit after a rising edge; inputs stay stable across the next edge.
  task automatic cycle(input bit en, input bit w, input logic [2:0] wa, input logic [15:0] wd,
                       input bit ra_e, input logic [2:0] ra, input bit rb_e, input logic [2:0] rb);
    clk_en = en; we = w; waddr = wa; wdata = wd;
    re_a = ra_e; raddr_a = ra; re_b = rb_e; raddr_b = rb;
    model_step();
    @(posedge clk_n);
    #1;
    check_all();
  endtask

  // Mid-cycle asynchronous reset; outputs must clear before the next edge.
  task automatic reset_pulse();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #3;
    check_all();
    rst = 1'b0;

    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 3'(i), 16'hAAAA, 1'b0, 3'd0, 1'b0, 3'd0);
    reset_pulse();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 1'b1, 3'(7 - i));

    repeat (3) cycle(1'b0, 1'b1, 3'd3, 16'h1111, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 1'b0, 3'd0);
    check_eq("gate_off", rda[0], 16'h0000);
    cycle(1'b1, 1'b1, 3'd3, 16'h1111, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 1'b0, 3'd0);
    check_eq("gate_on", rda[0], 16'h1111);

    cycle(1'b1, 1'b1, 3'd2, 16'h2222, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle(1'b1, 1'b1, 3'd5, 16'h8888, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b1, 3'd5);
    check_eq("dual_a", rda[0], 16'h2222);
    check_eq("dual_b", rdb[0], 16'h8888);
    check_eq("dual_va", 16'(va[0]), 16'h0001);
    cycle(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0);
    check_eq("hold_va", 16'(va[0]), 16'h0000);
    check_eq("hold_a", rda[0], 16'h2222);

    cycle(1'b1, 1'b1, 3'd4, 16'h4444, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle(1'b1, 1'b1, 3'd4, 16'hCCCC, 1'b1, 3'd4, 1'b0, 3'd0);
`ifdef RF_WRITE_BYPASS_EN
    check_eq("collide", rda[0], 16'hCCCC);
`else
    check_eq("collide", rda[0], 16'h4444);
`endif
    cycle(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 1'b0, 3'd0);
    check_eq("collide_next", rda[0], 16'hCCCC);

    cycle(1'b1, 1'b1, 3'd7, 16'hFFFF, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 1'b1, 3'd5);
    check_eq("oor_data", rda[1], 16'h0000);
    check_eq("oor_valid", 16'(va[1]), 16'h0001);
    check_eq("oor_neighbour", rdb[1], 16'h8888);
    cycle(1'b1, 1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 1'b1, 3'd0);
    check_eq("zero_r0", rda[1], 16'h0000);
    check_eq("r0_normal", rdb[0], 16'hFFFF);

    repeat (3000) begin
      logic [2:0] wa, ra, rb;
      if ($urandom_range(0, 99) == 0) reset_pulse();
      wa = 3'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, wa, 16'($urandom),
            $urandom_range(0, 1) == 1, ra, $urandom_range(0, 1) == 1, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rf_multiport_ce.md
# rf_multiport_ce

Parametrised register file: WIDTH-bit entries, DEPTH deep, one synchronous write port, two registered read ports, and a global clock enable that freezes the whole block. Successor to the single 16-bit clock-enabled register. Used as the general-purpose register bank of the datapath. All storage and outputs update on the rising edge of `clk_n` only while `clk_en` is high.

## Interface
- `WIDTH`, 16, bits per entry (≥1)
- `DEPTH`, 8, number of entries (≥2; need not be a power of two)
- `AW`, $clog2(DEPTH), address width (derived; do not override)
- `ZERO_R0`, 0, when 1, entry 0 always reads 0 and ignores writes
- `clk_n`  in  1  clock; all state changes on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `clk_en`  in  1  global enable; low = no state change anywhere
- `we`  in  1  write enable
- `waddr`  in  AW  write address
- `wdata`  in  WIDTH  write data
- `re_a`, `re_b`  in  1  read enables, ports A/B
- `raddr_a`, `raddr_b`  in  AW  read addresses
- `rdata_a`, `rdata_b`  out  WIDTH  registered read data
- `rvalid_a`, `rvalid_b`  out  1  high for one enabled cycle after an accepted read

## Operation
- Reset (`rst`=1, any time, independent of clock): all entries, `rdata_*` and `rvalid_*` go to 0 immediately; held while `rst` high.
- Write: on rising `clk_n` with `clk_en`=1, `we`=1, `waddr`<DEPTH → entry[waddr] ← wdata. `waddr`≥DEPTH: write dropped, nothing changes.
- `ZERO_R0`=1: writes to address 0 dropped; reads of 0 return 0.
- Read (per port, independent): on rising `clk_n` with `clk_en`=1 and `re_x`=1 → `rdata_x` ← entry[raddr_x] (0 if `raddr_x`≥DEPTH), `rvalid_x` ← 1.
- `clk_en`=1, `re_x`=0 → `rdata_x` holds previous value, `rvalid_x` ← 0.
- `clk_en`=0 → every register (entries, `rdata_*`, `rvalid_*`) holds; `rvalid_x` stays at its last value (pulse stretches; consumer qualifies with its own enable).
- Both ports may read the same address; both return identical data.
- Read and write to same address same edge: see Configuration.

## Timing
- Write latency: data visible in storage after the enabled edge; a read issued on the following enabled edge returns it (2 edges wdata→rdata without bypass).
- Read latency: 1 enabled edge from `re_x`/`raddr_x` to `rdata_x`/`rvalid_x`.
- Outputs purely registered; no combinational path from any input to `rdata_*`/`rvalid_*`.
- `rst` deassertion is synchronised externally; block requires no recovery cycles beyond that.
- Throughput: one write plus two reads per enabled cycle, no stalls.

## Configuration
- Macro `RF_WRITE_BYPASS_EN`.
- Defined: read on same edge as write to the same valid address (and not suppressed by `ZERO_R0`) returns `wdata` (write-first); per port.
- Undefined: same case returns the old entry contents (read-first); new data visible from next enabled read.
- Dropped writes (out of range, `ZERO_R0`, `clk_en`=0) never bypass in either build.

## Test plan
- Reset: write 0xAAAA to all entries, pulse `rst` mid-cycle → `rdata_a/b`=0x0000, `rvalid_*`=0 before next edge; subsequent reads of every address return 0x0000.
- Enable gating: `clk_en`=0, `we`=1 `waddr`=3 `wdata`=0x1111 for 3 edges, then `clk_en`=1, read addr 3 → 0x0000; repeat with `clk_en`=1 → 0x1111 one edge after read.
- Dual read: write 2←0x2222, 5←0x8888; read A=2, B=5 same edge → `rdata_a`=0x2222, `rdata_b`=0x8888, both `rvalid` high for one edge, then low with `re`=0 while data held.
- Collision: entry 4=0x4444, write 4←0xCCCC and read A=4 same edge → 0xCCCC with `RF_WRITE_BYPASS_EN`, 0x4444 without; next read → 0xCCCC in both.
- Boundaries: DEPTH=6, write addr 7←0xFFFF → no entry changes; read addr 7 → 0x0000 with `rvalid`=1; `ZERO_R0`=1 write 0←0xFFFF → reads 0x0000.
